// File: rtl/fsm_monitor.sv
// Observer for the one-hot A..E sequence detector: binary state code, one-hot
// integrity flags, saturating match counter and run-length statistics of z.
module fsm_monitor #(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned RUN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               z,
  input  logic               a_state,
  input  logic               b_state,
  input  logic               c_state,
  input  logic               d_state,
  input  logic               e_state,
  input  logic               clear,
  output logic [2:0]         state_code,
  output logic               onehot_err,
  output logic               err_sticky,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_ovf,
  output logic [RUN_W-1:0]   run_len,
  output logic [RUN_W-1:0]   max_run
);

  localparam int unsigned CODE_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [RUN_W-1:0]   RUN_MAX   = '1;
  localparam logic [CODE_W-1:0]  CODE_BAD  = CODE_W'(7);

  logic [4:0]         state_bits;
  logic               rise;

  logic [CODE_W-1:0]  state_code_q,  state_code_d;
  logic               onehot_err_q,  onehot_err_d;
  logic               err_sticky_q,  err_sticky_d;
  logic [COUNT_W-1:0] match_count_q, match_count_d;
  logic               count_ovf_q,   count_ovf_d;
  logic [RUN_W-1:0]   run_len_q,     run_len_d;
  logic [RUN_W-1:0]   max_run_q,     max_run_d;
  logic               z_prev_q,      z_prev_d;

  assign state_bits = {e_state, d_state, c_state, b_state, a_state};
  assign rise       = z & ~z_prev_q;

  // Decode the detector state; anything not exactly one-hot maps to 7.
  always_comb begin
    state_code_d = CODE_BAD;
    onehot_err_d = 1'b0;
    case (state_bits)
      5'b00001: state_code_d = CODE_W'(0);
      5'b00010: state_code_d = CODE_W'(1);
      5'b00100: state_code_d = CODE_W'(2);
      5'b01000: state_code_d = CODE_W'(3);
      5'b10000: state_code_d = CODE_W'(4);
      default:  onehot_err_d = 1'b1;
    endcase
  end

  // Statistics next-state; clear overrides every update in its cycle.
  always_comb begin
    z_prev_d      = z;
    err_sticky_d  = err_sticky_q | onehot_err_d;
    match_count_d = match_count_q;
    count_ovf_d   = count_ovf_q;
    run_len_d     = RUN_W'(0);
    max_run_d     = max_run_q;

    if (rise) begin
      if (match_count_q == COUNT_MAX) count_ovf_d   = 1'b1;
      else                            match_count_d = match_count_q + COUNT_W'(1);
    end

    if (z) begin
      run_len_d = (run_len_q == RUN_MAX) ? RUN_MAX : run_len_q + RUN_W'(1);
    end
    if (run_len_d > max_run_q) max_run_d = run_len_d;

    if (clear) begin
      err_sticky_d  = 1'b0;
      match_count_d = COUNT_W'(0);
      count_ovf_d   = 1'b0;
      run_len_d     = RUN_W'(0);
      max_run_d     = RUN_W'(0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_code_q  <= CODE_W'(0);
      onehot_err_q  <= 1'b0;
      err_sticky_q  <= 1'b0;
      match_count_q <= COUNT_W'(0);
      count_ovf_q   <= 1'b0;
      run_len_q     <= RUN_W'(0);
      max_run_q     <= RUN_W'(0);
      z_prev_q      <= 1'b0;
    end else begin
      state_code_q  <= state_code_d;
      onehot_err_q  <= onehot_err_d;
      err_sticky_q  <= err_sticky_d;
      match_count_q <= match_count_d;
      count_ovf_q   <= count_ovf_d;
      run_len_q     <= run_len_d;
      max_run_q     <= max_run_d;
      z_prev_q      <= z_prev_d;
    end
  end

  assign state_code  = state_code_q;
  assign onehot_err  = onehot_err_q;
  assign err_sticky  = err_sticky_q;
  assign match_count = match_count_q;
  assign count_ovf   = count_ovf_q;
  assign run_len     = run_len_q;
  assign max_run     = max_run_q;

endmodule

// File: tb/tb_fsm_monitor.sv
// Randomized and directed bench for fsm_monitor against an arithmetic
// reference model of the observer statistics.
module tb_fsm_monitor;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned RUN_W   = 4;
  localparam int CMAX = (1 << COUNT_W) - 1;
  localparam int RMAX = (1 << RUN_W) - 1;
  localparam int VW = 3 + 1 + 1 + COUNT_W + 1 + RUN_W + RUN_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic z = 1'b0, clear = 1'b0;
  logic a_state = 1'b0, b_state = 1'b0, c_state = 1'b0, d_state = 1'b0, e_state = 1'b0;
  logic [2:0]         state_code;
  logic               onehot_err, err_sticky, count_ovf;
  logic [COUNT_W-1:0] match_count;
  logic [RUN_W-1:0]   run_len, max_run;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers).
  int m_code = 0, m_err = 0, m_sticky = 0, m_count = 0, m_ovf = 0;
  int m_run = 0, m_max = 0, m_zprev = 0;

  fsm_monitor #(.COUNT_W(COUNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .reset(reset), .z(z),
    .a_state(a_state), .b_state(b_state), .c_state(c_state),
    .d_state(d_state), .e_state(e_state), .clear(clear),
    .state_code(state_code), .onehot_err(onehot_err), .err_sticky(err_sticky),
    .match_count(match_count), .count_ovf(count_ovf),
    .run_len(run_len), .max_run(max_run)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {state_code, onehot_err, err_sticky, match_count, count_ovf, run_len, max_run};

  function automatic logic [VW-1:0] exp_vec();
    return {3'(m_code), 1'(m_err), 1'(m_sticky), COUNT_W'(m_count), 1'(m_ovf),
            RUN_W'(m_run), RUN_W'(m_max)};
  endfunction

  function automatic void model_reset();
    m_code = 0; m_err = 0; m_sticky = 0; m_count = 0; m_ovf = 0;
    m_run = 0; m_max = 0; m_zprev = 0;
  endfunction

  // One clock of the model: inputs sampled at the edge, compared #1 later.
  task automatic step(input logic [4:0] bits, input logic zi, input logic clr);
    int ones, rise;
    {e_state, d_state, c_state, b_state, a_state} = bits;
    z = zi;
    clear = clr;
    @(posedge clk);
    ones = 0;
    m_code = 7;
    for (int i = 0; i < 5; i++) if (bits[i]) begin ones++; m_code = i; end
    m_err = (ones != 1);
    if (m_err) m_code = 7;
    rise = zi && !m_zprev;
    m_zprev = zi;
    if (clr) begin
      m_sticky = 0; m_count = 0; m_ovf = 0; m_run = 0; m_max = 0;
    end else begin
      m_sticky = m_sticky | m_err;
      if (rise) begin
        if (m_count == CMAX) m_ovf = 1;
        else m_count = m_count + 1;
      end
      m_run = zi ? ((m_run < RMAX) ? m_run + 1 : RMAX) : 0;
      if (m_run > m_max) m_max = m_run;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    model_reset();
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL reset_state got=%h want=0", dut_vec);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle_a();
    for (int i = 0; i < 3; i++) begin
      step(5'b00001, 1'b0, 1'b0);
      total++;
      if (dut_vec !== exp_vec() || state_code !== 3'd0 || onehot_err !== 1'b0 ||
          match_count !== 8'd0 || run_len !== 4'd0) begin
        bad++; $display("FAIL idle_a cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_run_e();
    for (int i = 1; i <= 5; i++) begin
      step(5'b10000, 1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec() || run_len !== RUN_W'(i) || state_code !== 3'd4) begin
        bad++; $display("FAIL run_e cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    step(5'b10000, 1'b0, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || match_count !== 8'd1 || run_len !== 4'd0 || max_run !== 4'd5) begin
      bad++; $display("FAIL run_e_end got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_onehot_err();
    step(5'b01100, 1'b0, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || state_code !== 3'd7 || onehot_err !== 1'b1 || err_sticky !== 1'b1) begin
      bad++; $display("FAIL onehot_bad got=%h want=%h", dut_vec, exp_vec());
    end
    step(5'b00010, 1'b0, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || state_code !== 3'd1 || onehot_err !== 1'b0 || err_sticky !== 1'b1) begin
      bad++; $display("FAIL onehot_recover got=%h want=%h", dut_vec, exp_vec());
    end
    step(5'b00000, 1'b0, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || state_code !== 3'd7 || onehot_err !== 1'b1) begin
      bad++; $display("FAIL onehot_zero got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_count_saturate();
    step(5'b00001, 1'b0, 1'b1);
    for (int i = 1; i <= 256; i++) begin
      step(5'b00001, 1'b1, 1'b0);
      if (i == 255 || i == 256) begin
        total++;
        if (dut_vec !== exp_vec() || match_count !== 8'd255 || count_ovf !== ((i == 256) ? 1'b1 : 1'b0)) begin
          bad++; $display("FAIL count_sat edge=%0d got=%h want=%h", i, dut_vec, exp_vec());
        end
      end
      step(5'b00001, 1'b0, 1'b0);
    end
  endtask

  task automatic test_run_saturate_clear();
    for (int i = 0; i < 20; i++) step(5'b00100, 1'b1, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || run_len !== 4'd15 || max_run !== 4'd15) begin
      bad++; $display("FAIL run_sat got=%h want=%h", dut_vec, exp_vec());
    end
    step(5'b00100, 1'b1, 1'b1);
    total++;
    if (dut_vec !== exp_vec() || match_count !== 8'd0 || run_len !== 4'd0 ||
        max_run !== 4'd0 || count_ovf !== 1'b0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL clear_cycle got=%h want=%h", dut_vec, exp_vec());
    end
    step(5'b00100, 1'b1, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || run_len !== 4'd1 || match_count !== 8'd0) begin
      bad++; $display("FAIL after_clear got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    logic zs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    step(5'b01000, 1'b0, 1'b1);
    foreach (zs[i]) step(5'b01000, zs[i], 1'b0);
    total++;
    if (dut_vec !== exp_vec() || match_count !== 8'd3 || run_len !== 4'd2) begin
      bad++; $display("FAIL pre_reset got=%h want=%h", dut_vec, exp_vec());
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL async_reset got=%h want=0", dut_vec);
    end
    #1 reset = 1'b0;
    step(5'b01000, 1'b1, 1'b0);
    total++;
    if (dut_vec !== exp_vec() || match_count !== 8'd1 || run_len !== 4'd1) begin
      bad++; $display("FAIL post_reset got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [4:0] bits;
    logic zi, clr;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      bits = (r < 8) ? 5'(1 << (r % 5)) : 5'($urandom);
      zi = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step(bits, zi, clr);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back_rise();
    step(5'b00001, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(5'b00001, 1'(i % 2 == 0), 1'b0);
    total++;
    if (dut_vec !== exp_vec() || match_count !== 8'd3 || max_run !== 4'd1) begin
      bad++; $display("FAIL back_to_back got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_idle_a();
    test_run_e();
    test_onehot_err();
    test_count_saturate();
    test_run_saturate_clear();
    test_async_reset();
    test_back_to_back_rise();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
